rv_decode: RTL and testbench
============================

// Module: rv_decode
// PURPOSE
//  RV32I instruction-decode (ID) stage of the 5-stage pipeline. Registers IF/ID IR and PC into ID/EX,
//  reads rs1/rs2 from the internal 32x32 register file, and produces the decoded, sign-extended
//  immediate. Accepts the MEM/WB write-back (IR + result) to update the register file.
// PARAMETERS
//  XLEN      32  datapath / register width
//  NREGS     32  architectural registers (x0 hardwired to zero)
// PORTS
//  clk         in   1     clock, all state updates on rising edge
//  rst         in   1     reset, asynchronous, active-low
//  if_id_ir    in   32    instruction from IF/ID latch
//  if_id_pc    in   32    PC of that instruction
//  mem_wb_ir   in   32    instruction in MEM/WB (rd = [11:7], opcode = [6:0])
//  mem_wb_out  in   32    write-back data for mem_wb_ir's rd
//  id_ex_ir    out  32    registered copy of if_id_ir
//  id_ex_pc    out  32    registered copy of if_id_pc
//  id_ex_rs1   out  32    registered regfile[if_id_ir[19:15]]
//  id_ex_rs2   out  32    registered regfile[if_id_ir[24:20]]
//  id_ex_imm   out  32    registered decoded immediate
// BEHAVIOUR
//  - Reset (rst=0, async): all id_ex_* outputs = 0; all 32 registers cleared to 0.
//  - Latency: one cycle; outputs reflect inputs sampled at the previous rising edge.
//  - rs1/rs2 fields read for every opcode (raw bit fields, no format gating).
//  - Immediate by opcode (ir = if_id_ir), sign-extended from its MSB (ir[31]) to 32 bits:
//      I  (0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM): ir[31:20]
//      S  (0100011): {ir[31:25], ir[11:7]}
//      B  (1100011): {ir[31], ir[7], ir[30:25], ir[11:8]}  (halfword units; EX applies <<1)
//      U  (0110111 LUI, 0010111 AUIPC): ir[31:12]          (unshifted; EX applies <<12)
//      J  (1101111): {ir[31], ir[19:12], ir[20], ir[30:21]} (halfword units; EX applies <<1)
//      R  (0110011) and every other/illegal opcode: 0
//  - Write-back: on rising edge, regfile[mem_wb_ir[11:7]] <= mem_wb_out when rd != 0 and
//    mem_wb_ir[6:0] is neither STORE (0100011) nor BRANCH (1100011). Opcode 0000000 writes.
//  - x0: writes ignored; reads always return 0.
//  - Same-edge write and read of one register: without bypass, read returns the old value.
// CONFIGURATION
//  WB_BYPASS_EN defined: when a write is enabled and mem_wb rd equals rs1 (or rs2), id_ex_rs1
//    (rs2) captures mem_wb_out in the same edge (write-through forwarding; never for x0).
//  Undefined: no forwarding; the read observes the value from before the write edge.
// STRUCTURE
//  - Package rv_pkg: opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE,
//    OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG), XLEN, IR field-slice helpers.
//  - Sub-module rv_regfile: 2 async read ports, 1 sync write port, async active-low clear.
//  - rv_decode: immediate generator (combinational), ID/EX pipeline registers, optional bypass.
// TESTING
//  1. Reset: rst=0 -> all id_ex_* = 0; with rst=1, read of x1..x31 returns 0.
//  2. Imm: ir opcode 0000011, ir[31:20]=fff -> id_ex_imm=ffff_ffff; same for S/B/U/J
//     all-ones fields -> ffff_ffff; R-type with ir[31:7] all ones -> 0; opcode 1001100 -> 0.
//  3. Positive imm: I-type ir[31:20]=7ff -> 0000_07ff; U-type ir[31:12]=12345 -> 0001_2345.
//  4. Write/read: mem_wb_ir rd=4, opcode 0, mem_wb_out=deadbeef for one edge; next cycle
//     if_id_ir rs1=4 -> id_ex_rs1=deadbeef one edge later.
//  5. x0 and gating: rd=0 write deadbeef -> rs1=0 reads 0; mem_wb opcode STORE with
//     ir[11:7]=5 -> x5 unchanged.
//  6. Bypass: same-edge write x7=cafef00d and read rs2=7 -> id_ex_rs2=cafef00d with
//     WB_BYPASS_EN defined, old x7 value without it.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I opcode constants, widths and IR field-slice helpers
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic [6:0] ir_opcode(input logic [31:0] ir);
    return ir[6:0];
  endfunction

  function automatic logic [AW-1:0] ir_rd(input logic [31:0] ir);
    return ir[11:7];
  endfunction

  function automatic logic [AW-1:0] ir_rs1(input logic [31:0] ir);
    return ir[19:15];
  endfunction

  function automatic logic [AW-1:0] ir_rs2(input logic [31:0] ir);
    return ir[24:20];
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// rtl/rv_regfile.sv - 32x32 register file, two async read ports, one sync write port
// x0 is never written and always reads as zero.
module rv_regfile
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/rv_decode.sv
// rtl/rv_decode.sv - RV32I ID stage: regfile read, immediate decode, ID/EX registers
// Optional write-through forwarding from MEM/WB when WB_BYPASS_EN is defined.
module rv_decode
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     if_id_ir,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic [31:0]     mem_wb_ir,
  input  logic [XLEN-1:0] mem_wb_out,
  output logic [31:0]     id_ex_ir,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1,
  output logic [XLEN-1:0] id_ex_rs2,
  output logic [XLEN-1:0] id_ex_imm
);

  logic [6:0]      wb_op;
  logic [AW-1:0]   wb_rd;
  logic            wb_we;
  logic [XLEN-1:0] rf_rs1, rf_rs2;
  logic [XLEN-1:0] rs1_d, rs2_d, imm_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;

  assign wb_op = ir_opcode(mem_wb_ir);
  assign wb_rd = ir_rd(mem_wb_ir);
  // Stores and branches reuse [11:7] as immediate bits, not a destination.
  assign wb_we = (wb_rd != '0) && (wb_op != OP_STORE) && (wb_op != OP_BRANCH);

  rv_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (ir_rs1(if_id_ir)),
    .raddr2_i (ir_rs2(if_id_ir)),
    .rdata1_o (rf_rs1),
    .rdata2_o (rf_rs2),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (mem_wb_out)
  );

`ifdef WB_BYPASS_EN
  assign rs1_d = (wb_we && (wb_rd == ir_rs1(if_id_ir))) ? mem_wb_out : rf_rs1;
  assign rs2_d = (wb_we && (wb_rd == ir_rs2(if_id_ir))) ? mem_wb_out : rf_rs2;
`else
  assign rs1_d = rf_rs1;
  assign rs2_d = rf_rs2;
`endif

  // B and J immediates stay in halfword units, U unshifted; EX applies the shift.
  always_comb begin
    imm_d = '0;
    case (ir_opcode(if_id_ir))
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm_d = {{20{if_id_ir[31]}}, if_id_ir[31:20]};
      OP_STORE:
        imm_d = {{20{if_id_ir[31]}}, if_id_ir[31:25], if_id_ir[11:7]};
      OP_BRANCH:
        imm_d = {{20{if_id_ir[31]}}, if_id_ir[31], if_id_ir[7], if_id_ir[30:25], if_id_ir[11:8]};
      OP_LUI, OP_AUIPC:
        imm_d = {{12{if_id_ir[31]}}, if_id_ir[31:12]};
      OP_JAL:
        imm_d = {{12{if_id_ir[31]}}, if_id_ir[31], if_id_ir[19:12], if_id_ir[20], if_id_ir[30:21]};
      default:
        imm_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q  <= '0;
      pc_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else begin
      ir_q  <= if_id_ir;
      pc_q  <= if_id_pc;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      imm_q <= imm_d;
    end
  end

  assign id_ex_ir  = ir_q;
  assign id_ex_pc  = pc_q;
  assign id_ex_rs1 = rs1_q;
  assign id_ex_rs2 = rs2_q;
  assign id_ex_imm = imm_q;

endmodule

// File: tb/tb_rv_decode.sv
// tb/tb_rv_decode.sv - directed scoreboard bench for rv_decode
module tb_rv_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_id_ir = '0, if_id_pc = '0, mem_wb_ir = '0, mem_wb_out = '0;
  logic [31:0] id_ex_ir, id_ex_pc, id_ex_rs1, id_ex_rs2, id_ex_imm;

  typedef struct {
    string       tag;
    logic [31:0] ir, pc, rs1, rs2, imm;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rf [32];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  rv_decode dut (
    .clk        (clk),
    .rst        (rst),
    .if_id_ir   (if_id_ir),
    .if_id_pc   (if_id_pc),
    .mem_wb_ir  (mem_wb_ir),
    .mem_wb_out (mem_wb_out),
    .id_ex_ir   (id_ex_ir),
    .id_ex_pc   (id_ex_pc),
    .id_ex_rs1  (id_ex_rs1),
    .id_ex_rs2  (id_ex_rs2),
    .id_ex_imm  (id_ex_imm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic model_we(input logic [31:0] wir);
    return (wir[11:7] != 5'd0) && (wir[6:0] != 7'b0100011) && (wir[6:0] != 7'b1100011);
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a, input logic [31:0] wir,
                                           input logic [31:0] wout);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : model_rf[a];
`ifdef WB_BYPASS_EN
    if (model_we(wir) && (wir[11:7] == a)) v = wout;
`endif
    return v;
  endfunction

  // Drive one cycle of inputs, push the expected ID/EX contents, then compare after the edge.
  task automatic step(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                      input logic [31:0] wir, input logic [31:0] wout, input logic [31:0] imm);
    exp_t e, got;
    e.tag = tag;
    e.ir  = ir;
    e.pc  = pc;
    e.rs1 = model_rd(ir[19:15], wir, wout);
    e.rs2 = model_rd(ir[24:20], wir, wout);
    e.imm = imm;
    sb.push_back(e);
    if_id_ir   = ir;
    if_id_pc   = pc;
    mem_wb_ir  = wir;
    mem_wb_out = wout;
    @(posedge clk);
    if (model_we(wir)) model_rf[wir[11:7]] = wout;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({got.tag, "_ir"},  id_ex_ir,  got.ir);
      chk({got.tag, "_pc"},  id_ex_pc,  got.pc);
      chk({got.tag, "_rs1"}, id_ex_rs1, got.rs1);
      chk({got.tag, "_rs2"}, id_ex_rs2, got.rs2);
      chk({got.tag, "_imm"}, id_ex_imm, got.imm);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    // Reset holds outputs at zero even while inputs toggle and clocks run.
    if_id_ir   = 32'hfff00003;
    if_id_pc   = 32'h0000_1000;
    mem_wb_ir  = 32'h0000_0200;
    mem_wb_out = 32'h1111_1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir",  id_ex_ir,  32'd0);
    chk("rst_pc",  id_ex_pc,  32'd0);
    chk("rst_rs1", id_ex_rs1, 32'd0);
    chk("rst_rs2", id_ex_rs2, 32'd0);
    chk("rst_imm", id_ex_imm, 32'd0);
    mem_wb_ir = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 1; r < 32; r++) begin
      logic [31:0] ir;
      ir = 32'd0;
      ir[19:15] = r[4:0];
      ir[24:20] = r[4:0];
      ir[6:0]   = 7'b0110011;
      step($sformatf("rst_read_x%0d", r), ir, 32'h100 + 32'(r), 32'd0, 32'd0, 32'd0);
    end

    step("imm_i_neg",   32'hfff00003, 32'h200, 32'd0, 32'd0, 32'hffff_ffff);
    step("imm_s_neg",   32'hfe000fa3, 32'h204, 32'd0, 32'd0, 32'hffff_ffff);
    step("imm_b_neg",   32'hfe000fe3, 32'h208, 32'd0, 32'd0, 32'hffff_ffff);
    step("imm_u_neg",   32'hfffff037, 32'h20c, 32'd0, 32'd0, 32'hffff_ffff);
    step("imm_j_neg",   32'hfffff06f, 32'h210, 32'd0, 32'd0, 32'hffff_ffff);
    step("imm_r_zero",  32'hffffffb3, 32'h214, 32'd0, 32'd0, 32'h0000_0000);
    step("imm_ill",     32'hffffffcc, 32'h218, 32'd0, 32'd0, 32'h0000_0000);
    step("imm_i_pos",   32'h7ff00013, 32'h21c, 32'd0, 32'd0, 32'h0000_07ff);
    step("imm_u_pos",   32'h12345037, 32'h220, 32'd0, 32'd0, 32'h0001_2345);
    step("imm_jalr",    32'h80000067, 32'h224, 32'd0, 32'd0, 32'hffff_f800);
    step("imm_system",  32'h80000073, 32'h228, 32'd0, 32'd0, 32'hffff_f800);
    step("imm_auipc",   32'h80000017, 32'h22c, 32'd0, 32'd0, 32'hfff8_0000);
    step("imm_s_mix",   32'h02000123, 32'h230, 32'd0, 32'd0, 32'h0000_0022);
    step("imm_b_mix",   32'h000000e3, 32'h234, 32'd0, 32'd0, 32'h0000_0400);
    step("imm_j_mix",   32'h0010006f, 32'h238, 32'd0, 32'd0, 32'h0000_0400);

    // Write x4 with opcode 0000000, then read it back through rs1.
    step("wb_x4",       32'h00000033, 32'h300, 32'h0000_0200, 32'hdeadbeef, 32'd0);
    step("rd_x4",       32'h00020033, 32'h304, 32'd0,         32'd0,        32'd0);

    // x0 ignores writes; STORE and BRANCH never write their [11:7] field.
    step("wb_x0",       32'h00000033, 32'h308, 32'h0000_0000, 32'hdeadbeef, 32'd0);
    step("rd_x0",       32'h00000033, 32'h30c, 32'd0,         32'd0,        32'd0);
    step("wb_x5",       32'h00000033, 32'h310, 32'h0000_0293, 32'h1111_1111, 32'd0);
    step("store_x5",    32'h00000033, 32'h314, 32'h0000_02a3, 32'h2222_2222, 32'd0);
    step("branch_x5",   32'h00000033, 32'h318, 32'h0000_02e3, 32'h3333_3333, 32'd0);
    step("rd_x5",       32'h00500033, 32'h31c, 32'd0,         32'd0,        32'd0);

    // Same-edge write and read of x7: old value unless forwarding is built in.
    step("wb_x7_old",   32'h00000033, 32'h320, 32'h0000_03b3, 32'h1234_5678, 32'd0);
    step("byp_x7",      32'h00738033, 32'h324, 32'h0000_03b3, 32'hcafef00d, 32'd0);
    step("rd_x7",       32'h00738033, 32'h328, 32'd0,         32'd0,        32'd0);
    step("byp_x4_rs1",  32'h00020033, 32'h32c, 32'h0000_0237, 32'h0bad_cafe, 32'd0);
    step("byp_x0",      32'h00000033, 32'h330, 32'h0000_0033, 32'h5555_5555, 32'd0);

    if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
